multi_led_blinker: RTL and testbench

Parametrised N-channel LED blinker. Each channel toggles its LED output at a runtime-programmable half-period.
- Per-channel enable.
- Global phase-resync input.
- Per-channel one-cycle toggle strobe.

The block sits between board-level LED pins and control logic (UART/debug registers, mode FSMs). It replaces fixed-rate hard-coded toggle counters.

---
 rtl/multi_led_blinker.sv | 99 +++++++++
 tb/tb_multi_led_blinker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_led_blinker.sv
// multi_led_blinker: NUM_CH independent LED blinkers. Each channel toggles its
// LED every half[ch] enabled clock cycles, with a shared write port for the
// half-period registers, a global phase-restart pulse and a per-channel
// registered toggle strobe.
module multi_led_blinker #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 24,
  parameter int DEFAULT_HALF = 6000000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_half,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_led,
  output logic [NUM_CH-1:0] o_tick
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // An index beyond the last channel addresses nothing; such writes are dropped.
  logic wr_valid;
  assign wr_valid = i_wr_en && (32'(i_wr_ch) < 32'(NUM_CH));

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] term;
    logic             led_q,  led_d;
    logic             tick_q, tick_d;
    logic             wr_hit;

    assign wr_hit = wr_valid && (i_wr_ch == CH_W'(ch));

    // A half-period of 0 behaves as 1, so the terminal count saturates at 0.
    assign term = (half_q == '0) ? '0 : (half_q - ONE);

    // Half-period register next state: load on a write addressed to this channel.
    always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      half_d = half_q;
      if (wr_hit) begin
        half_d = i_wr_half;
      end
    end

    // Counter / LED / strobe next state, in priority order: disable, resync, wrap, count.
    always_comb begin
      cnt_d  = cnt_q;
      led_d  = led_q;
      tick_d = 1'b0;
      if (!i_en[ch]) begin
        cnt_d = '0;
        led_d = 1'b0;
      end else if (i_sync) begin
        cnt_d = '0;
        led_d = 1'b0;
      end else if (cnt_q >= term) begin
        // >= rather than == so a counter left above a freshly shrunk terminal
        // wraps on the next edge instead of running up to 2^CNT_W.
        cnt_d  = '0;
        led_d  = ~led_q;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        // NOTE: the half-period registers are state the LEDs depend on, so they
        // are reset like any other flop; a programmed rate is lost on reset.
        half_q <= RST_HALF;
        cnt_q  <= '0;
        led_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        half_q <= half_d;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
        tick_q <= tick_d;
      end
    end

    assign o_led[ch]  = led_q;
    assign o_tick[ch] = tick_q;

    // The counter stays at or below the largest possible terminal (2^CNT_W - 2),
    // so the all-ones value is unreachable.
    a_cnt_bound : assert property (@(posedge CLK) disable iff (!RST_N) cnt_q != '1);
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed testbench for multi_led_blinker: a 4-channel instance with an
// 8-bit counter and half=3 default, plus a 1-channel 4-bit instance for the
// maximum half-period and the out-of-range write index.
module tb_multi_led_blinker;

  logic       CLK = 1'b0;
  logic       RST_N;

  logic       i_wr_en;
  logic [1:0] i_wr_ch;
  logic [7:0] i_wr_half;
  logic [3:0] i_en;
  logic       i_sync;
  logic [3:0] o_led;
  logic [3:0] o_tick;

  logic       m_wr_en;
  logic [0:0] m_wr_ch;
  logic [3:0] m_wr_half;
  logic [0:0] m_en;
  logic       m_sync;
  logic [0:0] m_led;
  logic [0:0] m_tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  multi_led_blinker #(.NUM_CH(4), .CNT_W(8), .DEFAULT_HALF(3)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch), .i_wr_half(i_wr_half),
    .i_en(i_en), .i_sync(i_sync),
    .o_led(o_led), .o_tick(o_tick)
  );

  multi_led_blinker #(.NUM_CH(1), .CNT_W(4), .DEFAULT_HALF(15)) dut_max (
    .CLK(CLK), .RST_N(RST_N),
    .i_wr_en(m_wr_en), .i_wr_ch(m_wr_ch), .i_wr_half(m_wr_half),
    .i_en(m_en), .i_sync(m_sync),
    .o_led(m_led), .o_tick(m_tick)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Expected LED level / strobe e edges after a channel starts from cnt=0.
  function automatic logic exp_led(input int h, input int e);
    return ((e / h) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input int h, input int e);
    return (e > 0) && ((e % h) == 0);
  endfunction

  function automatic logic [3:0] led_vec(input int h [4], input int e);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = exp_led(h[i], e);
    return v;
  endfunction

  function automatic logic [3:0] tick_vec(input int h [4], input int e);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = exp_tick(h[i], e);
    return v;
  endfunction

  task automatic do_reset();
    RST_N     = 1'b0;
    i_wr_en   = 1'b0; i_wr_ch = '0; i_wr_half = '0; i_en = '0; i_sync = 1'b0;
    m_wr_en   = 1'b0; m_wr_ch = '0; m_wr_half = '0; m_en = '0; m_sync = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(1);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] h);
    i_wr_en = 1'b1; i_wr_ch = ch; i_wr_half = h;
    step(1);
    i_wr_en = 1'b0;
  endtask

  initial begin
    int h_def [4];
    int h_prog [4];
    int h_sync [4];
    h_def  = '{3, 3, 3, 3};
    h_prog = '{3, 5, 1, 1};
    h_sync = '{3, 4, 7, 5};

    // 1. Reset defaults and async reset mid-count.
    do_reset();
    check("rst_led", 32'(o_led), 32'(4'h0));
    check("rst_tick", 32'(o_tick), 32'(4'h0));
    i_en = 4'hF;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      check($sformatf("def_led_e%0d", e), 32'(o_led), 32'(led_vec(h_def, e)));
      check($sformatf("def_tick_e%0d", e), 32'(o_tick), 32'(tick_vec(h_def, e)));
    end
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_led", 32'(o_led), 32'(4'h0));
    check("async_rst_tick", 32'(o_tick), 32'(4'h0));

    // 2. Programming ch1=5, ch2=0 (acts as 1), ch3=1 while disabled.
    do_reset();
    wr(2'd1, 8'd5);
    wr(2'd2, 8'd0);
    wr(2'd3, 8'd1);
    check("prog_idle_led", 32'(o_led), 32'(4'h0));
    i_en = 4'hF;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      check($sformatf("prog_led_e%0d", e), 32'(o_led), 32'(led_vec(h_prog, e)));
      check($sformatf("prog_tick_e%0d", e), 32'(o_tick), 32'(tick_vec(h_prog, e)));
    end

    // 3. Shrink half below the running count.
    do_reset();
    wr(2'd0, 8'd200);
    i_en = 4'b0001;
    step(150);
    check("shrink_pre_led", 32'(o_led[0]), 32'(1'b0));
    i_wr_en = 1'b1; i_wr_ch = 2'd0; i_wr_half = 8'd10;
    for (int e = 151; e <= 172; e++) begin
      step(1);
      i_wr_en = 1'b0;
      // Toggles at 152 (first edge using the new terminal), then 162, 172.
      check($sformatf("shrink_led_e%0d", e), 32'(o_led[0]), 32'(exp_led(10, e - 142)));
      check($sformatf("shrink_tick_e%0d", e), 32'(o_tick[0]), 32'(exp_tick(10, e - 142)));
    end

    // 4. Enable gating on ch2.
    do_reset();
    i_en = 4'hF;
    step(3);
    check("gate_on_led", 32'(o_led), 32'(4'hF));
    i_en = 4'b1011;
    step(1);
    check("gate_off_led", 32'(o_led), 32'(4'b1011));
    check("gate_off_tick", 32'(o_tick), 32'(4'h0));
    step(2);
    check("gate_e6_led", 32'(o_led), 32'(4'h0));
    check("gate_e6_tick", 32'(o_tick), 32'(4'b1011));
    step(1);
    check("gate_e7_led2", 32'(o_led[2]), 32'(1'b0));
    i_en = 4'hF;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      check($sformatf("gate_re_led2_e%0d", e), 32'(o_led[2]), 32'(exp_led(3, e)));
      check($sformatf("gate_re_tick2_e%0d", e), 32'(o_tick[2]), 32'(exp_tick(3, e)));
    end

    // 5. Sync with channels out of phase, then write+sync together.
    do_reset();
    wr(2'd1, 8'd4);
    wr(2'd2, 8'd7);
    wr(2'd3, 8'd5);
    i_en = 4'hF;
    step(11);
    check("sync_pre_led", 32'(o_led), 32'(4'b0101));
    i_sync = 1'b1;
    step(1);
    i_sync = 1'b0;
    check("sync_led", 32'(o_led), 32'(4'h0));
    check("sync_tick", 32'(o_tick), 32'(4'h0));
    for (int e = 1; e <= 8; e++) begin
      step(1);
      check($sformatf("sync_led_e%0d", e), 32'(o_led), 32'(led_vec(h_sync, e)));
      check($sformatf("sync_tick_e%0d", e), 32'(o_tick), 32'(tick_vec(h_sync, e)));
    end
    i_sync = 1'b1;
    i_wr_en = 1'b1; i_wr_ch = 2'd1; i_wr_half = 8'd2;
    step(1);
    i_sync = 1'b0; i_wr_en = 1'b0;
    check("wsync_led", 32'(o_led), 32'(4'h0));
    for (int e = 1; e <= 4; e++) begin
      step(1);
      check($sformatf("wsync_led1_e%0d", e), 32'(o_led[1]), 32'(exp_led(2, e)));
      check($sformatf("wsync_tick1_e%0d", e), 32'(o_tick[1]), 32'(exp_tick(2, e)));
    end

    // 6. Maximum half on a 4-bit counter; out-of-range write ignored.
    do_reset();
    m_wr_en = 1'b1; m_wr_ch = 1'b1; m_wr_half = 4'd2;
    step(1);
    m_wr_en = 1'b0;
    m_en = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      step(1);
      check($sformatf("max_led_e%0d", e), 32'(m_led), 32'(exp_led(15, e)));
      check($sformatf("max_tick_e%0d", e), 32'(m_tick), 32'(exp_tick(15, e)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
